// File: rtl/chacha_ks_sched.sv
// chacha_ks_sched: sequences chacha_core and streams each 512-bit keystream block as WORD_W words
module chacha_ks_sched #(
    parameter int WORD_W = 32,
    parameter int PREFETCH = 1,
    localparam int NWORDS = 512 / WORD_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [255:0]   key,
    input  logic [63:0]    iv,
    input  logic [63:0]    ctr_init,
    input  logic [31:0]    num_blocks,
    output logic           core_init,
    output logic           core_next,
    output logic [255:0]   core_key,
    output logic [63:0]    core_iv,
    output logic [63:0]    core_ctr,
    input  logic           core_ready,
    input  logic [511:0]   core_data_out,
    input  logic           core_data_valid,
    output logic [WORD_W-1:0] ks_data,
    output logic           ks_valid,
    input  logic           ks_ready,
    output logic           busy,
    output logic           done,
    output logic           exhausted,
    output logic [31:0]    blk_count
);
    localparam int IW = $clog2(NWORDS);
    typedef enum logic [2:0] {IDLE, INIT, WAIT_INIT, REQ, WAIT_BLK, SERVE, DRAIN} state_t;
    state_t state, nxt;
    logic [511:0] blk_buf;
    logic [IW-1:0] idx;
    logic [63:0] ctr;
    logic [31:0] nblk, issued;
    logic [1:0] ign;
    logic last, pf_pend, pf_rdy;
    logic seen, core_hit, acc, last_word, more, cap_pf, cap_wb, finish, outstanding, issue, go;
    // core status is stale for the pulse cycle and the one after it
    assign seen = ign == 2'd0;
    assign core_hit = seen && core_data_valid;
    assign acc = ks_valid && ks_ready;
    assign last_word = acc && idx == IW'(NWORDS - 1);
    assign more = !last && (nblk == 32'd0 || issued != nblk);
    assign cap_pf = last_word && pf_pend && (pf_rdy || core_hit);
    assign cap_wb = state == WAIT_BLK && core_hit;
    assign finish = last_word && !pf_pend && !more && !abort;
    assign go = state == IDLE && nxt == INIT;
    assign busy = state != IDLE;
    assign ks_data = ks_valid ? blk_buf[511 - WORD_W * int'(idx) -: WORD_W] : '0;
    assign outstanding = state == INIT || state == REQ
        || (state == WAIT_INIT && !(seen && core_ready))
        || (state == WAIT_BLK && !core_hit)
        || (state == SERVE && pf_pend && !pf_rdy && !core_hit);
    assign issue = nxt == REQ
        || (PREFETCH != 0 && nxt == SERVE && (state != SERVE || cap_pf) && more);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start && !abort ? INIT : IDLE;
            INIT:      nxt = WAIT_INIT;
            WAIT_INIT: nxt = seen && core_ready ? REQ : WAIT_INIT;
            REQ:       nxt = WAIT_BLK;
            WAIT_BLK:  nxt = cap_wb ? SERVE : WAIT_BLK;
            SERVE:     nxt = !last_word ? SERVE : cap_pf ? SERVE : pf_pend ? WAIT_BLK : more ? REQ : IDLE;
            DRAIN:     nxt = seen && (core_ready || core_data_valid) ? IDLE : DRAIN;
            default:   nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != DRAIN)
            nxt = outstanding ? DRAIN : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            core_init <= 1'b0;
            core_next <= 1'b0;
            core_key <= '0;
            core_iv <= '0;
            core_ctr <= '0;
            ks_valid <= 1'b0;
            done <= 1'b0;
            exhausted <= 1'b0;
            blk_count <= '0;
            blk_buf <= '0;
            idx <= '0;
            ctr <= '0;
            nblk <= '0;
            issued <= '0;
            ign <= '0;
            last <= 1'b0;
            pf_pend <= 1'b0;
            pf_rdy <= 1'b0;
        end else begin
            state <= nxt;
            core_init <= go;
            core_next <= issue;
            ks_valid <= nxt == SERVE;
            done <= finish;
            ign <= issue || go ? 2'd2 : seen ? ign : ign - 2'd1;
            idx <= last_word || nxt != SERVE ? '0 : idx + IW'(acc);
            if (go) begin
                core_key <= key;
                core_iv <= iv;
                ctr <= ctr_init;
                nblk <= num_blocks;
                issued <= '0;
                last <= 1'b0;
                blk_count <= '0;
                exhausted <= 1'b0;
            end
            if (issue) begin
                core_ctr <= ctr;
                issued <= issued + 32'd1;
                if (&ctr) last <= 1'b1;
                else ctr <= ctr + 64'd1;
            end
            if (cap_pf || cap_wb) blk_buf <= core_data_out;
            else if (abort) blk_buf <= '0;
            if (last_word && !(&blk_count)) blk_count <= blk_count + 32'd1;
            if (finish && last) exhausted <= 1'b1;
            if (issue && nxt == SERVE) begin
                pf_pend <= 1'b1;
                pf_rdy <= 1'b0;
            end else if (cap_pf || cap_wb || nxt == IDLE || nxt == DRAIN) begin
                pf_pend <= 1'b0;
                pf_rdy <= 1'b0;
            end else if (state == SERVE && pf_pend && core_hit) pf_rdy <= 1'b1;
        end
    end
endmodule

// File: tb/tb_chacha_ks_sched.sv
// tb_chacha_ks_sched: directed sessions against a behavioural chacha_core stand-in
module tb_chacha_ks_sched;
    logic clk = 0, rst = 1, start = 0, abort = 0;
    logic [255:0] key = {4{64'h0123_4567_89ab_cdef}};
    logic [63:0] iv = 64'hdeadbeefcafebabe, ctr_init = '0;
    logic [31:0] num_blocks = '0;
    logic core_init, core_next, core_ready, core_data_valid;
    logic [255:0] core_key;
    logic [63:0] core_iv, core_ctr;
    logic [511:0] core_data_out;
    logic [31:0] ks_data, blk_count;
    logic ks_valid, ks_ready = 1, busy, done, exhausted;
    int checks = 0, errors = 0;
    int lat = 6, cnt = 0;
    logic nmode = 0;
    logic [63:0] cc = '0;
    int acc_n, n_init, n_next, n_done, gaps, rdy_mode;
    logic serving, stalled;
    logic [31:0] held;
    logic [63:0] c0;
    logic [63:0] nctr [4];

    always #5 clk = ~clk;

    chacha_ks_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .key(key), .iv(iv),
        .ctr_init(ctr_init), .num_blocks(num_blocks), .core_init(core_init),
        .core_next(core_next), .core_key(core_key), .core_iv(core_iv), .core_ctr(core_ctr),
        .core_ready(core_ready), .core_data_out(core_data_out), .core_data_valid(core_data_valid),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy), .done(done),
        .exhausted(exhausted), .blk_count(blk_count)
    );

    function automatic logic [31:0] kw(input logic [63:0] c, input int i);
        return (c[31:0] * 32'h9E37_79B1) ^ c[63:32] ^ (32'h0101_0101 * 32'(i)) ^ 32'h5a5a_0000;
    endfunction

    function automatic logic [511:0] blk(input logic [63:0] c);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32 * i -: 32] = kw(c, i);
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            core_ready <= 1'b1;
            core_data_valid <= 1'b0;
            core_data_out <= '0;
            cnt <= 0;
        end else if (core_init || core_next) begin
            core_ready <= 1'b0;
            core_data_valid <= 1'b0;
            cnt <= lat;
            nmode <= core_next;
            cc <= core_ctr;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                core_ready <= 1'b1;
                core_data_valid <= nmode;
                if (nmode) core_data_out <= blk(cc);
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (core_init) n_init++;
        if (core_next) begin
            if (n_next < 4) nctr[n_next] = core_ctr;
            n_next++;
        end
        if (done) n_done++;
        if (stalled) begin
            check("stall_valid", ks_valid, 1);
            check("stall_data", ks_data, held);
        end
        if (ks_valid) serving = 1;
        if (serving && busy && !ks_valid) gaps++;
        ks_ready = rdy_mode == 0 ? 1'b1 : ~ks_ready;
        stalled = ks_valid && !ks_ready;
        held = ks_data;
        if (ks_valid && ks_ready) begin
            check("word", ks_data, kw(c0 + 64'(acc_n / 16), acc_n % 16));
            acc_n++;
        end
    endtask

    task automatic kick(input logic [63:0] c, input logic [31:0] nb, input int mode);
        c0 = c; acc_n = 0; n_init = 0; n_next = 0; n_done = 0; gaps = 0;
        serving = 0; stalled = 0; rdy_mode = mode;
        ctr_init = c; num_blocks = nb; start = 1;
        step();
        start = 0;
    endtask

    task automatic session(input logic [63:0] c, input logic [31:0] nb, input int mode);
        kick(c, nb, mode);
        for (int i = 0; i < 3000 && n_done == 0; i++) step();
        check("session_done", n_done, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_valid", ks_valid, 0);
        check("rst_init", core_init, 0);
        check("rst_next", core_next, 0);
        check("rst_key", core_key, 0);
        check("rst_blk", blk_count, 0);
        rst = 0;
        step();

        session(64'd0, 32'd1, 0);
        check("b_init", n_init, 1);
        check("b_next", n_next, 1);
        check("b_ctr0", nctr[0], 0);
        check("b_words", acc_n, 16);
        check("b_blk", blk_count, 1);
        check("b_key", core_key, key);
        check("b_iv", core_iv, iv);
        step();
        check("b_done_pulse", done, 0);

        session(64'd0, 32'd3, 0);
        check("s_next", n_next, 3);
        check("s_ctr0", nctr[0], 0);
        check("s_ctr1", nctr[1], 1);
        check("s_ctr2", nctr[2], 2);
        check("s_words", acc_n, 48);
        check("s_gaps", gaps, 0);
        check("s_blk", blk_count, 3);

        session(64'h100, 32'd2, 1);
        check("bp_words", acc_n, 32);
        check("bp_blk", blk_count, 2);
        check("bp_next", n_next, 2);
        check("bp_exh", exhausted, 0);

        session(64'hFFFF_FFFF_FFFF_FFFE, 32'd0, 0);
        repeat (20) step();
        check("x_next", n_next, 2);
        check("x_ctr1", nctr[1], 64'hFFFF_FFFF_FFFF_FFFF);
        check("x_words", acc_n, 32);
        check("x_exh", exhausted, 1);
        check("x_blk", blk_count, 2);
        check("x_done", n_done, 1);

        lat = 40;
        kick(64'd5, 32'd0, 0);
        check("a_exh_clr", exhausted, 0);
        for (int i = 0; i < 600 && acc_n < 6; i++) step();
        check("a_reach", acc_n, 6);
        abort = 1;
        step();
        abort = 0;
        check("a_valid", ks_valid, 0);
        check("a_drain", busy, 1);
        start = 1;
        step();
        start = 0;
        check("a_drain_start", busy, 1);
        for (int i = 0; i < 200 && busy; i++) step();
        repeat (3) step();
        check("a_idle", busy, 0);
        check("a_no_done", n_done, 0);
        check("a_no_reinit", n_init, 1);
        check("a_ready", core_ready, 1);
        lat = 6;

        kick(64'h77, 32'd0, 0);
        for (int i = 0; i < 300 && acc_n < 3; i++) step();
        check("r_reach", acc_n, 3);
        rst = 1;
        step();
        check("r_valid", ks_valid, 0);
        check("r_busy", busy, 0);
        check("r_data", ks_data, 0);
        check("r_ctr", core_ctr, 0);
        check("r_key", core_key, 0);
        check("r_iv", core_iv, 0);
        check("r_next", core_next, 0);
        check("r_blk", blk_count, 0);
        rst = 0;
        step();

        start = 1;
        abort = 1;
        step();
        start = 0;
        abort = 0;
        check("sa_busy", busy, 0);
        step();
        check("sa_init", core_init, 0);
        check("sa_busy2", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
